act_requant_stage: RTL

- Downstream consumer of the 3x3 matrix-vector multiplier output stream.
- Takes 16-bit signed accumulator results plus their overflow flag over a valid/ready handshake.
- Applies optional ReLU, round-half-up arithmetic right shift, and saturation to 8-bit signed.
- Emits an 8-bit stream with vector-boundary marking, ready to feed the next layer's 8-bit data input.

---
 rtl/nn_pkg.sv | 58 +++++
 rtl/act_requant_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// Shared widths, output limits and the scalar requantisation reference for the NN datapath.
package nn_pkg;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned OUT_W_DEF = 8;
    localparam int          OUT_MAX   = 127;
    localparam int          OUT_MIN   = -128;

    typedef struct packed {
        logic signed [OUT_W_DEF-1:0] value;
        logic                        sat;
    } rq_t;

    // Full requantisation of one accumulator word: overflow forcing, ReLU, rounded shift, clamp.
    function automatic rq_t requant(input logic signed [IN_W_DEF-1:0] x,
                                    input logic                       ovf,
                                    input int unsigned                shift,
                                    input logic                       relu);
        rq_t                       r;
        logic signed [IN_W_DEF:0]  xe;
        logic signed [IN_W_DEF:0]  rnd;
        logic signed [IN_W_DEF:0]  v;
        r.sat   = 1'b0;
        r.value = '0;
        xe      = '0;
        rnd     = '0;
        v       = '0;
        if (ovf) begin
            // A single wrap flips the sign bit, so the true sign is its inverse.
            r.sat = 1'b1;
            if (x[IN_W_DEF-1]) begin
                r.value = OUT_W_DEF'(OUT_MAX);
            end else begin
                r.value = relu ? '0 : OUT_W_DEF'(OUT_MIN);
            end
        end else begin
            xe = {x[IN_W_DEF-1], x};
            if (relu && xe[IN_W_DEF]) begin
                xe = '0;
            end
            if (shift > 0) begin
                rnd = (IN_W_DEF+1)'(1) << (shift - 1);
            end
            v = (xe + rnd) >>> shift;
            if (v > (IN_W_DEF+1)'(OUT_MAX)) begin
                r.value = OUT_W_DEF'(OUT_MAX);
                r.sat   = 1'b1;
            end else if (v < (IN_W_DEF+1)'(OUT_MIN)) begin
                r.value = OUT_W_DEF'(OUT_MIN);
                r.sat   = 1'b1;
            end else begin
                r.value = OUT_W_DEF'(v);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/act_requant_stage.sv
// Two-stage requantiser: 16-bit signed accumulators in, 8-bit saturated activations out.
module act_requant_stage
    import nn_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned SHIFT   = 4,
    parameter bit          RELU_EN = 1'b1,
    parameter int unsigned VEC_LEN = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  s_data,
    input  logic                    s_ovf,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_last,
    output logic                    m_sat,
    output logic [15:0]             sat_count,
    output logic                    ovf_seen
);

    localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned VW    = IN_W + 1;

    localparam logic signed [VW-1:0]    RND   = (SHIFT > 0) ? (VW'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [VW-1:0]    V_MAX = VW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [VW-1:0]    V_MIN = VW'(-(1 << (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0] D_MAX = OUT_W'(V_MAX);
    localparam logic signed [OUT_W-1:0] D_MIN = OUT_W'(V_MIN);

    logic                    s1_valid;
    logic signed [VW-1:0]    s1_v;
    logic                    s1_ovf;
    logic                    s1_neg;
    logic                    s1_last;
    logic [CNT_W-1:0]        elem_cnt;

    logic                    s2_load;
    logic                    in_fire;
    logic                    out_fire;
    logic signed [VW-1:0]    x_ext;
    logic signed [VW-1:0]    x_relu;
    logic signed [VW-1:0]    v_c;
    logic signed [OUT_W-1:0] s2_data_c;
    logic                    s2_sat_c;

    // Handshake: S2 refills when empty or draining; S1 moves whenever S2 refills.
    always_comb begin
        s2_load  = !m_valid || m_ready;
        s_ready  = !s1_valid || s2_load;
        in_fire  = s_valid && s_ready;
        out_fire = m_valid && m_ready;
    end

    // S1 datapath: optional ReLU, then round-half-up arithmetic shift in IN_W+1 bits.
    always_comb begin
        x_ext  = {s_data[IN_W-1], s_data};
        x_relu = (RELU_EN && x_ext[VW-1]) ? '0 : x_ext;
        v_c    = (x_relu + RND) >>> SHIFT;
    end

    // S1 register: shifted value plus overflow, true-sign and vector-end tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_ovf   <= 1'b0;
            s1_neg   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (s_ready) begin
            s1_valid <= s_valid;
            if (s_valid) begin
                s1_v    <= v_c;
                s1_ovf  <= s_ovf;
                s1_neg  <= ~s_data[IN_W-1];
                s1_last <= (elem_cnt == CNT_W'(VEC_LEN - 1));
            end
        end
    end

    // S2 datapath: overflow forcing or clamp to the signed output range.
    always_comb begin
        s2_data_c = OUT_W'(s1_v);
        s2_sat_c  = 1'b0;
        if (s1_ovf) begin
            s2_sat_c  = 1'b1;
            s2_data_c = s1_neg ? (RELU_EN ? '0 : D_MIN) : D_MAX;
        end else if (s1_v > V_MAX) begin
            s2_sat_c  = 1'b1;
            s2_data_c = D_MAX;
        end else if (s1_v < V_MIN) begin
            s2_sat_c  = 1'b1;
            s2_data_c = D_MIN;
        end
    end

    // S2 register drives the output port directly and holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_sat   <= 1'b0;
        end else if (s2_load) begin
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_data <= s2_data_c;
                m_last <= s1_last;
                m_sat  <= s2_sat_c;
            end
        end
    end

    // Element position within the current vector, advanced per accepted input.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_cnt <= '0;
        end else if (in_fire) begin
            elem_cnt <= (elem_cnt == CNT_W'(VEC_LEN - 1)) ? '0 : elem_cnt + CNT_W'(1);
        end
    end

    // Status: saturating count of clamped outputs and sticky input-overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
            ovf_seen  <= 1'b0;
        end else begin
            if (out_fire && m_sat && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (in_fire && s_ovf) begin
                ovf_seen <= 1'b1;
            end
        end
    end

endmodule
